// File: rtl/ctrl_decode_pipe.sv
// RV32I/M control decoder with a registered E-stage bundle, stall/flush handling
// and a multi-cycle MUL/DIV sequencer that holds E and raises busy toward F/D.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | E register follows D (capture, hold on stall, bubble on flush)
// RUN   | M op occupies E; busy = 1; counter counts down to the exit edge
module ctrl_decode_pipe #(
    parameter bit ENABLE_M   = 1'b1,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic        stall_in,
    input  logic        flush_in,
    output logic        busy,
    output logic        e_valid,
    output logic        e_reg_write,
    output logic [1:0]  e_result_src,
    output logic [1:0]  e_mem_size,
    output logic        e_load_sign,
    output logic        e_mem_write,
    output logic        e_jump,
    output logic        e_jump_src,
    output logic        e_branch,
    output logic        e_invert_cond,
    output logic [3:0]  e_alu_control,
    output logic        e_alu_src_a,
    output logic        e_alu_src_b,
    output logic [2:0]  e_imm_src,
    output logic [2:0]  e_muldiv_op,
    output logic        e_muldiv_start,
    output logic        e_illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] RES_ALU    = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_PC4    = 2'd2;
    localparam logic [1:0] RES_MULDIV = 2'd3;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // Counter holds "edges left before exit", so it loads cycles-1.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] mem_size;
        logic       load_sign;
        logic       mem_write;
        logic       jump;
        logic       jump_src;
        logic       branch;
        logic       invert_cond;
        logic [3:0] alu_control;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] imm_src;
        logic [2:0] muldiv_op;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic arith);
        logic [3:0] op;
        case (f3)
            3'd0:    op = ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = arith ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [1:0] size_from_f3(input logic [2:0] f3);
        return (f3[1:0] == 2'd3) ? 2'd2 : f3[1:0];
    endfunction

    ctrl_t  dec;
    ctrl_t  cap;
    ctrl_t  e_q;
    logic   d_muldiv;
    logic   d_div;
    logic   cap_start;
    logic   e_valid_q;
    logic   start_q;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic   hold;

    always_comb begin
        dec      = '0;
        d_muldiv = 1'b0;
        d_div    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.reg_write   = 1'b1;
                dec.alu_control = ALU_PASS_B;
                dec.alu_src_b   = 1'b1;
                dec.imm_src     = IMM_U;
            end
            OPC_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm_src   = IMM_U;
            end
            OPC_JAL: begin
                dec.reg_write  = 1'b1;
                dec.result_src = RES_PC4;
                dec.jump       = 1'b1;
                dec.alu_src_a  = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.imm_src    = IMM_J;
            end
            OPC_JALR: begin
                dec.reg_write  = 1'b1;
                dec.result_src = RES_PC4;
                dec.jump       = 1'b1;
                dec.jump_src   = 1'b1;
                dec.alu_src_b  = 1'b1;
                dec.imm_src    = IMM_I;
            end
            OPC_BRANCH: begin
                dec.branch      = 1'b1;
                dec.invert_cond = funct3[0];
                dec.imm_src     = IMM_B;
                case (funct3[2:1])
                    2'd0:    dec.alu_control = ALU_SUB;
                    2'd2:    dec.alu_control = ALU_SLT;
                    2'd3:    dec.alu_control = ALU_SLTU;
                    default: dec.illegal     = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.result_src = RES_MEM;
                dec.mem_size   = size_from_f3(funct3);
                dec.load_sign  = funct3[2];
                dec.alu_src_b  = 1'b1;
                dec.imm_src    = IMM_I;
                dec.illegal    = (funct3 == 3'd3);
            end
            OPC_STORE: begin
                dec.mem_write = 1'b1;
                dec.mem_size  = size_from_f3(funct3);
                dec.alu_src_b = 1'b1;
                dec.imm_src   = IMM_S;
                dec.illegal   = (funct3 >= 3'd3);
            end
            OPC_OP_IMM: begin
                dec.reg_write   = 1'b1;
                dec.alu_src_b   = 1'b1;
                dec.imm_src     = IMM_I;
                dec.alu_control = alu_from_f3(funct3, funct7[5]);
                if (funct3 == 3'd1)
                    dec.illegal = (funct7 != F7_BASE);
                else if (funct3 == 3'd5)
                    dec.illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
            end
            OPC_OP: begin
                dec.reg_write = 1'b1;
                case (funct7)
                    F7_BASE: dec.alu_control = alu_from_f3(funct3, 1'b0);
                    F7_ALT: begin
                        if (funct3 == 3'd0)
                            dec.alu_control = ALU_SUB;
                        else if (funct3 == 3'd5)
                            dec.alu_control = ALU_SRA;
                        else
                            dec.illegal = 1'b1;
                    end
                    F7_MULDIV: begin
                        if (ENABLE_M) begin
                            dec.result_src = RES_MULDIV;
                            dec.muldiv_op  = funct3;
                            d_muldiv       = 1'b1;
                            d_div          = funct3[2];
                        end else begin
                            dec.illegal = 1'b1;
                        end
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            // Fences and system ops decode as harmless no-ops.
            OPC_FENCE, OPC_SYSTEM: ;
            default: dec.illegal = 1'b1;
        endcase
    end

    always_comb begin
        cap         = dec;
        cap.illegal = dec.illegal & instr_valid;
        if (!instr_valid || dec.illegal) begin
            cap.reg_write = 1'b0;
            cap.mem_write = 1'b0;
            cap.jump      = 1'b0;
            cap.branch    = 1'b0;
        end
    end

    assign cap_start = instr_valid & ~dec.illegal & d_muldiv;
    assign busy      = (state == RUN);
    // The exit edge of RUN is also a capture edge.
    assign hold      = stall_in || ((state == RUN) && (cnt != '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q       <= '0;
            e_valid_q <= 1'b0;
            start_q   <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
        end else if (flush_in) begin
            e_valid_q     <= 1'b0;
            e_q.reg_write <= 1'b0;
            e_q.mem_write <= 1'b0;
            e_q.jump      <= 1'b0;
            e_q.branch    <= 1'b0;
            e_q.illegal   <= 1'b0;
            start_q       <= 1'b0;
            state         <= IDLE;
        end else begin
            if (state == RUN) begin
                if (cnt == '0)
                    state <= IDLE;
                else
                    cnt <= cnt - 1'b1;
            end
            if (hold) begin
                start_q <= 1'b0;
            end else begin
                e_q       <= cap;
                e_valid_q <= instr_valid;
                start_q   <= cap_start;
                if (cap_start) begin
                    state <= RUN;
                    cnt   <= d_div ? DIV_LOAD : MUL_LOAD;
                end
            end
        end
    end

    assign e_valid        = e_valid_q;
    assign e_reg_write    = e_q.reg_write;
    assign e_result_src   = e_q.result_src;
    assign e_mem_size     = e_q.mem_size;
    assign e_load_sign    = e_q.load_sign;
    assign e_mem_write    = e_q.mem_write;
    assign e_jump         = e_q.jump;
    assign e_jump_src     = e_q.jump_src;
    assign e_branch       = e_q.branch;
    assign e_invert_cond  = e_q.invert_cond;
    assign e_alu_control  = e_q.alu_control;
    assign e_alu_src_a    = e_q.alu_src_a;
    assign e_alu_src_b    = e_q.alu_src_b;
    assign e_imm_src      = e_q.imm_src;
    assign e_muldiv_op    = e_q.muldiv_op;
    assign e_muldiv_start = start_q;
    assign e_illegal      = e_q.illegal;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Bench for ctrl_decode_pipe: directed scenarios plus a randomized run checked
// against a cycles-remaining pipeline model with an instruction-table decoder.
module tb_ctrl_decode_pipe;

    localparam int MULC = 3;
    localparam int DIVC = 33;
    localparam int ALU_BY_F3 [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LBU  = 32'h0000C103;
    localparam logic [31:0] I_MUL  = 32'h02208033;
    localparam logic [31:0] I_MUL1 = 32'h022080B3;
    localparam logic [31:0] I_DIV  = 32'h023140B3;
    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, instr_valid = 1'b0, stall_in = 1'b0, flush_in = 1'b0;
    logic [31:0] instr = 32'h0;

    logic busy, e_valid, e_reg_write, e_load_sign, e_mem_write, e_jump, e_jump_src;
    logic e_branch, e_invert_cond, e_alu_src_a, e_alu_src_b, e_muldiv_start, e_illegal;
    logic [1:0] e_result_src, e_mem_size;
    logic [3:0] e_alu_control;
    logic [2:0] e_imm_src, e_muldiv_op;

    logic n_busy, n_valid, n_reg_write, n_load_sign, n_mem_write, n_jump, n_jump_src;
    logic n_branch, n_invert_cond, n_alu_src_a, n_alu_src_b, n_muldiv_start, n_illegal;
    logic [1:0] n_result_src, n_mem_size;
    logic [3:0] n_alu_control;
    logic [2:0] n_imm_src, n_muldiv_op;

    ctrl_decode_pipe #(.ENABLE_M(1'b1), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .stall_in(stall_in), .flush_in(flush_in), .busy(busy), .e_valid(e_valid),
        .e_reg_write(e_reg_write), .e_result_src(e_result_src), .e_mem_size(e_mem_size),
        .e_load_sign(e_load_sign), .e_mem_write(e_mem_write), .e_jump(e_jump),
        .e_jump_src(e_jump_src), .e_branch(e_branch), .e_invert_cond(e_invert_cond),
        .e_alu_control(e_alu_control), .e_alu_src_a(e_alu_src_a), .e_alu_src_b(e_alu_src_b),
        .e_imm_src(e_imm_src), .e_muldiv_op(e_muldiv_op), .e_muldiv_start(e_muldiv_start),
        .e_illegal(e_illegal)
    );

    ctrl_decode_pipe #(.ENABLE_M(1'b0), .MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_W(6)) dut_nom (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .stall_in(stall_in), .flush_in(flush_in), .busy(n_busy), .e_valid(n_valid),
        .e_reg_write(n_reg_write), .e_result_src(n_result_src), .e_mem_size(n_mem_size),
        .e_load_sign(n_load_sign), .e_mem_write(n_mem_write), .e_jump(n_jump),
        .e_jump_src(n_jump_src), .e_branch(n_branch), .e_invert_cond(n_invert_cond),
        .e_alu_control(n_alu_control), .e_alu_src_a(n_alu_src_a), .e_alu_src_b(n_alu_src_b),
        .e_imm_src(n_imm_src), .e_muldiv_op(n_muldiv_op), .e_muldiv_start(n_muldiv_start),
        .e_illegal(n_illegal)
    );

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] mem_size;
        logic       load_sign;
        logic       mem_write;
        logic       jump;
        logic       jump_src;
        logic       branch;
        logic       invert_cond;
        logic [3:0] alu_control;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] imm_src;
        logic [2:0] muldiv_op;
        logic       muldiv_start;
        logic       illegal;
    } exp_t;

    int checks = 0;
    int errors = 0;

    exp_t m_e    = '0;
    exp_t m_mask = '1;
    int   m_busy = 0;

    function automatic logic [25:0] dut_vec();
        return {e_valid, e_reg_write, e_result_src, e_mem_size, e_load_sign, e_mem_write,
                e_jump, e_jump_src, e_branch, e_invert_cond, e_alu_control, e_alu_src_a,
                e_alu_src_b, e_imm_src, e_muldiv_op, e_muldiv_start, e_illegal};
    endfunction

    // Instruction-class table: what each RV32I/M form should ask of the datapath.
    function automatic exp_t ref_decode(input logic [31:0] w, output bit is_m, output bit is_div);
        exp_t r;
        logic [2:0] f3;
        logic [6:0] f7;
        r = '0;
        f3 = w[14:12];
        f7 = w[31:25];
        is_m = 1'b0;
        is_div = 1'b0;
        case (w[6:0])
            7'h37: begin r.reg_write = 1; r.alu_control = 4'd10; r.alu_src_b = 1; r.imm_src = 3; end
            7'h17: begin r.reg_write = 1; r.alu_src_a = 1; r.alu_src_b = 1; r.imm_src = 3; end
            7'h6F: begin
                r.reg_write = 1; r.result_src = 2; r.jump = 1;
                r.alu_src_a = 1; r.alu_src_b = 1; r.imm_src = 4;
            end
            7'h67: begin
                r.reg_write = 1; r.result_src = 2; r.jump = 1; r.jump_src = 1; r.alu_src_b = 1;
            end
            7'h63: begin
                r.branch = 1;
                r.imm_src = 2;
                r.invert_cond = (f3 == 1 || f3 == 5 || f3 == 7);
                if (f3 == 2 || f3 == 3) r.illegal = 1;
                else r.alu_control = (f3 < 4) ? 4'd1 : ((f3 < 6) ? 4'd3 : 4'd4);
            end
            7'h03: begin
                r.reg_write = 1; r.result_src = 1; r.alu_src_b = 1;
                r.mem_size = (f3 % 4 == 3) ? 2'd2 : 2'(f3 % 4);
                r.load_sign = (f3 >= 4);
                r.illegal = (f3 == 3);
            end
            7'h23: begin
                r.mem_write = 1; r.alu_src_b = 1; r.imm_src = 1;
                r.mem_size = (f3 % 4 == 3) ? 2'd2 : 2'(f3 % 4);
                r.illegal = (f3 >= 3);
            end
            7'h13: begin
                r.reg_write = 1; r.alu_src_b = 1;
                r.alu_control = 4'(ALU_BY_F3[f3]);
                if (f3 == 1 && f7 != 0) r.illegal = 1;
                if (f3 == 5) begin
                    if (f7 == 7'h20) r.alu_control = 4'd7;
                    else if (f7 != 0) r.illegal = 1;
                end
            end
            7'h33: begin
                r.reg_write = 1;
                if (f7 == 0) r.alu_control = 4'(ALU_BY_F3[f3]);
                else if (f7 == 7'h20 && f3 == 0) r.alu_control = 4'd1;
                else if (f7 == 7'h20 && f3 == 5) r.alu_control = 4'd7;
                else if (f7 == 7'h01) begin
                    r.result_src = 3; r.muldiv_op = f3; is_m = 1; is_div = (f3 >= 4);
                end else r.illegal = 1;
            end
            7'h0F, 7'h73: ;
            default: r.illegal = 1;
        endcase
        return r;
    endfunction

    // Model of the E stage: m_busy is the number of busy cycles still ahead.
    task automatic model_step();
        exp_t r;
        bit is_m, is_div;
        if (reset) begin
            m_e = '0; m_mask = '1; m_busy = 0;
        end else if (flush_in) begin
            m_e.valid = 0; m_e.reg_write = 0; m_e.mem_write = 0; m_e.jump = 0;
            m_e.branch = 0; m_e.illegal = 0; m_e.muldiv_start = 0;
            m_busy = 0;
        end else if (m_busy > 1) begin
            m_busy--;
            m_e.muldiv_start = 0;
        end else begin
            m_busy = 0;
            if (stall_in) begin
                m_e.muldiv_start = 0;
            end else begin
                r = ref_decode(instr, is_m, is_div);
                r.valid = instr_valid;
                m_mask = '1;
                if (!instr_valid || r.illegal) begin
                    r.reg_write = 0; r.mem_write = 0; r.jump = 0; r.branch = 0;
                    m_mask = '0;
                    m_mask.valid = 1; m_mask.reg_write = 1; m_mask.mem_write = 1;
                    m_mask.jump = 1; m_mask.branch = 1; m_mask.muldiv_start = 1; m_mask.illegal = 1;
                end
                r.illegal = r.illegal & instr_valid;
                r.muldiv_start = instr_valid && !r.illegal && is_m;
                if (r.muldiv_start) m_busy = is_div ? DIVC : MULC;
                m_e = r;
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; instr_valid = 0; stall_in = 0; flush_in = 0;
        step(); step();
        reset = 0;
        checks++;
        if ({busy, dut_vec()} !== 27'd0) begin
            errors++; $display("FAIL reset_idle: got %h want 0", {busy, dut_vec()});
        end
        instr = I_DIV; instr_valid = 1;
        step();
        instr_valid = 0;
        repeat (4) step();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL div_busy_c5: got %b want 1", busy); end
        reset = 1;
        step();
        reset = 0;
        checks++;
        if ({busy, dut_vec()} !== 27'd0) begin
            errors++; $display("FAIL reset_mid_run: got %h want 0", {busy, dut_vec()});
        end
    endtask

    task automatic test_alu_load();
        instr = I_ADDI; instr_valid = 1;
        step();
        checks++;
        if ({e_valid, e_reg_write, e_alu_control, e_alu_src_b, e_imm_src, e_result_src} !==
            {1'b1, 1'b1, 4'd0, 1'b1, 3'd0, 2'd0}) begin
            errors++;
            $display("FAIL addi: got v%b rw%b alu%0d b%b imm%0d res%0d want v1 rw1 alu0 b1 imm0 res0",
                     e_valid, e_reg_write, e_alu_control, e_alu_src_b, e_imm_src, e_result_src);
        end
        instr = I_LBU;
        step();
        checks++;
        if ({e_mem_size, e_load_sign, e_result_src, e_reg_write} !== {2'd0, 1'b1, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL lbu: got size%0d sign%b res%0d rw%b want size0 sign1 res1 rw1",
                     e_mem_size, e_load_sign, e_result_src, e_reg_write);
        end
        instr_valid = 0;
        step();
    endtask

    task automatic test_mul();
        int busy_cycles;
        instr = I_MUL; instr_valid = 1;
        step();
        checks++;
        if ({e_muldiv_start, busy, e_result_src, e_muldiv_op} !== {1'b1, 1'b1, 2'd3, 3'd0}) begin
            errors++;
            $display("FAIL mul_capture: got start%b busy%b res%0d op%0d want start1 busy1 res3 op0",
                     e_muldiv_start, busy, e_result_src, e_muldiv_op);
        end
        instr = I_ADD;
        busy_cycles = 1;
        for (int k = 2; k <= 4; k++) begin
            step();
            if (busy) busy_cycles++;
            checks++;
            if (e_muldiv_start !== 1'b0) begin
                errors++; $display("FAIL mul_start_pulse: edge %0d got %b want 0", k, e_muldiv_start);
            end
        end
        checks++;
        if (busy_cycles != MULC) begin
            errors++; $display("FAIL mul_busy_len: got %0d want %0d", busy_cycles, MULC);
        end
        checks++;
        if ({busy, e_result_src, e_reg_write, e_valid} !== {1'b0, 2'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mul_next_add: got busy%b res%0d rw%b v%b want busy0 res0 rw1 v1",
                     busy, e_result_src, e_reg_write, e_valid);
        end
        instr_valid = 0;
        step();
    endtask

    task automatic test_back_to_back();
        instr = I_MUL; instr_valid = 1;
        step();
        instr = I_MUL1;
        step(); step(); step();
        checks++;
        if ({e_muldiv_start, busy, e_valid} !== 3'b111) begin
            errors++; $display("FAIL b2b_restart: got start%b busy%b v%b want 111",
                               e_muldiv_start, busy, e_valid);
        end
        instr_valid = 0;
        step(); step(); step();
        checks++;
        if ({busy, e_valid} !== 2'b00) begin
            errors++; $display("FAIL b2b_exit: got busy%b v%b want 00", busy, e_valid);
        end
    endtask

    task automatic test_div_flush();
        instr = I_DIV; instr_valid = 1;
        step();
        instr = I_ADD;
        repeat (9) step();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL div_c10_busy: got %b want 1", busy); end
        flush_in = 1;
        step();
        flush_in = 0;
        checks++;
        if ({busy, e_valid, e_reg_write} !== 3'b000) begin
            errors++; $display("FAIL div_flush: got busy%b v%b rw%b want 000", busy, e_valid, e_reg_write);
        end
        step();
        checks++;
        if ({busy, e_valid, e_reg_write, e_result_src} !== {3'b011, 2'd0}) begin
            errors++; $display("FAIL div_flush_next: got busy%b v%b rw%b res%0d want busy0 v1 rw1 res0",
                               busy, e_valid, e_reg_write, e_result_src);
        end
        instr_valid = 0;
        step();
    endtask

    task automatic test_stall_branch();
        instr = I_BNE; instr_valid = 1;
        step();
        instr = I_ADD; stall_in = 1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({e_valid, e_branch, e_invert_cond, e_imm_src, e_reg_write} !== {3'b111, 3'd2, 1'b0}) begin
                errors++;
                $display("FAIL bne_stall%0d: got v%b br%b inv%b imm%0d rw%b want v1 br1 inv1 imm2 rw0",
                         k, e_valid, e_branch, e_invert_cond, e_imm_src, e_reg_write);
            end
        end
        flush_in = 1;
        step();
        flush_in = 0;
        checks++;
        if ({e_valid, e_branch, e_imm_src} !== {2'b00, 3'd2}) begin
            errors++; $display("FAIL flush_over_stall: got v%b br%b imm%0d want v0 br0 imm2",
                               e_valid, e_branch, e_imm_src);
        end
        stall_in = 0;
        step();
        checks++;
        if ({e_valid, e_reg_write, e_branch} !== 3'b110) begin
            errors++; $display("FAIL after_stall_add: got v%b rw%b br%b want 110", e_valid, e_reg_write, e_branch);
        end
    endtask

    task automatic test_no_m();
        int nbusy;
        instr = I_MUL; instr_valid = 1;
        step();
        checks++;
        if ({n_illegal, n_reg_write, n_muldiv_start, n_busy} !== 4'b1000) begin
            errors++; $display("FAIL nom_mul: got ill%b rw%b start%b busy%b want 1000",
                               n_illegal, n_reg_write, n_muldiv_start, n_busy);
        end
        instr_valid = 0;
        nbusy = 0;
        repeat (4) begin
            step();
            if (n_busy !== 1'b0) nbusy++;
        end
        checks++;
        if (nbusy != 0) begin errors++; $display("FAIL nom_busy: got %0d busy cycles want 0", nbusy); end
        instr = I_BAD; instr_valid = 1;
        step();
        checks++;
        if ({e_illegal, n_illegal, e_reg_write, e_valid} !== 4'b1101) begin
            errors++; $display("FAIL opcode_7f: got ill%b nill%b rw%b v%b want 1101",
                               e_illegal, n_illegal, e_reg_write, e_valid);
        end
        instr_valid = 0;
        step();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0] f7;
        w = $urandom();
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom());
        endcase
        case ($urandom_range(0, 10))
            0: w[6:0] = 7'h37;
            1: w[6:0] = 7'h17;
            2: w[6:0] = 7'h6F;
            3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h03;
            6: w[6:0] = 7'h23;
            7: begin w[6:0] = 7'h13; w[31:25] = f7; end
            8: begin w[6:0] = 7'h33; w[31:25] = f7; end
            9: w[6:0] = ($urandom_range(0, 1) != 0) ? 7'h0F : 7'h73;
            default: ;
        endcase
        return w;
    endfunction

    task automatic test_random();
        logic [25:0] got, want, msk;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            reset       = ($urandom_range(0, 199) == 0);
            flush_in    = ($urandom_range(0, 99) < 4);
            stall_in    = ($urandom_range(0, 99) < 12);
            instr_valid = ($urandom_range(0, 99) < 85);
            instr       = rand_instr();
            step();
            checks++;
            if (busy !== (m_busy > 0)) begin
                errors++; $display("FAIL rand_busy cyc %0d: got %b want %b", cyc, busy, m_busy > 0);
            end
            got = dut_vec();
            want = m_e;
            msk = m_mask;
            checks++;
            if ((got & msk) !== (want & msk)) begin
                errors++;
                $display("FAIL rand_bundle cyc %0d instr %h: got %h want %h mask %h",
                         cyc, instr, got, want, msk);
            end
        end
        reset = 0; flush_in = 0; stall_in = 0; instr_valid = 0;
    endtask

    initial begin
        test_reset();
        test_alu_load();
        test_mul();
        test_back_to_back();
        test_div_flush();
        test_stall_branch();
        test_no_m();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
- Parametrised successor to the combinational control decoder.
- Decodes a full 32-bit RV32I/M instruction in D, registers the control bundle into the E stage, and honours pipeline stall and flush.
- Adds a multi-cycle MUL/DIV sequencer that holds the E bundle and asserts busy back to fetch/decode for a programmable number of cycles.
- Flags illegal encodings.

Parameters:
- ENABLE_M, 1, 1 = decode M-extension; 0 = M encodings are illegal.
- MUL_CYCLES, 3, cycles a MUL* op occupies E (>=1).
- DIV_CYCLES, 33, cycles a DIV*/REM* op occupies E (>=1).
- CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  D-stage instruction valid.
- instr  in  32  D-stage instruction word.
- stall_in  in  1  hazard-unit stall; holds E register.
- flush_in  in  1  hazard-unit flush; bubbles E.
- busy  out  1  muldiv sequencer active; F/D must hold.
- e_valid  out  1  E bundle valid.
- e_reg_write  out  1  register write enable.
- e_result_src  out  2  0 ALU, 1 MEM, 2 PC+4, 3 MULDIV.
- e_mem_size  out  2  0 byte, 1 half, 2 word (from funct3[1:0]; 3 maps to word).
- e_load_sign  out  1  0 signed, 1 unsigned (funct3[2]).
- e_mem_write  out  1  store.
- e_jump  out  1  JAL/JALR.
- e_jump_src  out  1  0 PC-relative, 1 register (JALR).
- e_branch  out  1  conditional branch.
- e_invert_cond  out  1  BNE/BGE/BGEU.
- e_alu_control  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- e_alu_src_a  out  1  0 rs1, 1 PC.
- e_alu_src_b  out  1  0 rs2, 1 imm.
- e_imm_src  out  3  0 I, 1 S, 2 B, 3 U, 4 J.
- e_muldiv_op  out  3  funct3 of M op.
- e_muldiv_start  out  1  one-cycle start pulse to muldiv unit.
- e_illegal  out  1  illegal instruction in E.

Behaviour:
- Reset: all e_* outputs are 0, busy is 0, FSM is IDLE, counter is 0. Reset overrides flush, stall and FSM.
- Decode is combinational in D. The E register captures it at the clock edge, giving 1-cycle latency from D to E.
- E register update priority, per edge:
  - reset;
  - else flush_in: e_valid, e_reg_write, e_mem_write, e_jump, e_branch, e_illegal, e_muldiv_start go to 0, and the FSM returns to IDLE (aborts any muldiv);
  - else busy or stall_in: hold all fields, e_muldiv_start goes to 0;
  - else capture, with e_valid = instr_valid.
- When instr_valid = 0, or e_illegal = 1, the captured bundle has all write/jump/branch enables forced to 0.
- Illegal: unknown opcode; bad funct7 on OP/shift-imm; funct3 = 3 on loads/stores or >= 3 on stores; undefined branch funct3; M encoding when ENABLE_M = 0. The result is e_illegal = 1, qualified by instr_valid.
- M op: opcode 0110011 with funct7 = 0000001 sets e_result_src = 3, e_reg_write = 1, e_muldiv_op = funct3. funct3 < 4 selects MUL, otherwise DIV.
- FSM states: IDLE and RUN.
  - IDLE -> RUN when a valid, non-flushed M op is captured. The counter loads the cycle count minus 1 (MUL_CYCLES or DIV_CYCLES). e_muldiv_start is registered to 1.
  - RUN: busy = 1. The counter decrements each edge.
  - RUN -> IDLE on the edge where the counter is 0, or on flush_in.
  - Result: an M op holds E for exactly MUL_CYCLES or DIV_CYCLES cycles, and the next instruction is captured on the edge that exits RUN, if stall_in = 0.
- busy is a combinational decode of state == RUN. It does not depend on stall_in.
- stall_in during RUN: the counter still decrements. If stall_in is still high at exit, E holds after exit with the FSM in IDLE; no re-trigger.
- Back-to-back M ops: the second is captured on the exit edge and re-enters RUN immediately, with a new start pulse.
- Counter does not wrap: it is loaded only on entry.

Test Plan:
- Reset mid-RUN (DIV, cycle 5) -> next cycle busy = 0, e_valid = 0, all e_* = 0.
- ADDI x1,x0,5 (0x00500093) valid -> after 1 edge: e_valid = 1, e_reg_write = 1, e_alu_control = 0, e_alu_src_b = 1, e_imm_src = 0, e_result_src = 0; LBU (funct3 = 4) -> e_mem_size = 0, e_load_sign = 1, e_result_src = 1.
- MUL (0x02208033) with MUL_CYCLES = 3 -> e_muldiv_start high 1 cycle, busy high exactly 3 cycles, following ADD captured on the 4th edge.
- DIV with DIV_CYCLES = 33, flush_in asserted at RUN cycle 10 -> next cycle busy = 0, e_valid = 0; a following valid ADD is captured normally.
- stall_in held 2 cycles on a BNE -> E holds BNE with e_branch = 1, e_invert_cond = 1, e_imm_src = 2; flush + stall together -> bubble wins.
- ENABLE_M = 0 with MUL -> e_illegal = 1, e_reg_write = 0, busy never asserts; opcode 0x7F -> e_illegal = 1.
